servant_mem_arb: RTL and testbench

- Two-master, one-slave Wishbone arbiter that shares the single servant_ram port between the CPU memory bus (master 0) and a secondary master (master 1: loader/debug/DMA).
- Sits between servile's memory bus and servant_ram.
- Registered grant with round-robin or fixed priority.
- Watchdog that error-terminates a stalled transfer so neither master can hang the SoC.

---
 rtl/servant_mem_arb_pkg.sv | 18 +
 rtl/servant_mem_arb_wdog.sv | 31 +++
 rtl/servant_mem_arb.sv | 139 +++++++++++++
 tb/tb_servant_mem_arb.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/servant_mem_arb_pkg.sv
// Shared definitions for the servant memory arbiter: FSM states, owner codes
// and the default read data returned on a watchdog termination.
package servant_mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Owner codes are one-hot so the registered owner can drive o_grant directly
  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_M0   = 2'b01;
  localparam logic [1:0] OWN_M1   = 2'b10;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;
  localparam int unsigned WDOG_W           = 8;

endpackage

// File: rtl/servant_mem_arb_wdog.sv
// Watchdog counter for a granted transfer: counts enabled cycles and flags the
// last permitted cycle before the transfer must be terminated.
module servant_mem_arb_wdog
  import servant_mem_arb_pkg::*;
#(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [WDOG_W-1:0] LAST = WDOG_W'(LIMIT - 1);

  logic [WDOG_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = (cnt == LAST);

endmodule

// File: rtl/servant_mem_arb.sv
// Two-master Wishbone arbiter in front of servant_ram: registered grant,
// round-robin or fixed priority, and a watchdog that error-terminates stalls.
module servant_mem_arb
  import servant_mem_arb_pkg::*;
#(
  parameter int unsigned AW       = 32,
  parameter              PRIO     = "RR",
  parameter int unsigned TIMEOUT  = 15,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic          i_wb_clk,
  input  logic          i_wb_rst_n,
  input  logic [AW-1:0] i_wb_m0_adr,
  input  logic [31:0]   i_wb_m0_dat,
  input  logic [3:0]    i_wb_m0_sel,
  input  logic          i_wb_m0_we,
  input  logic          i_wb_m0_cyc,
  output logic [31:0]   o_wb_m0_rdt,
  output logic          o_wb_m0_ack,
  input  logic [AW-1:0] i_wb_m1_adr,
  input  logic [31:0]   i_wb_m1_dat,
  input  logic [3:0]    i_wb_m1_sel,
  input  logic          i_wb_m1_we,
  input  logic          i_wb_m1_cyc,
  output logic [31:0]   o_wb_m1_rdt,
  output logic          o_wb_m1_ack,
  output logic [AW-1:0] o_wb_s_adr,
  output logic [31:0]   o_wb_s_dat,
  output logic [3:0]    o_wb_s_sel,
  output logic          o_wb_s_we,
  output logic          o_wb_s_cyc,
  input  logic [31:0]   i_wb_s_rdt,
  input  logic          i_wb_s_ack,
  output logic [1:0]    o_grant,
  output logic          o_timeout
);

  localparam bit FIXED_M0 = (PRIO == "M0");

  state_t     state, state_nxt;
  logic [1:0] owner, owner_nxt;
  logic [1:0] last, last_nxt;

  logic busy, own_m0, own_m1, own_cyc, expire, tmo, done;

  assign busy    = (state == BUSY);
  assign own_m0  = busy && (owner == OWN_M0);
  assign own_m1  = busy && (owner == OWN_M1);
  assign own_cyc = (own_m0 && i_wb_m0_cyc) || (own_m1 && i_wb_m1_cyc);
  // A real slave ack on the expiry cycle takes precedence over the timeout
  assign tmo     = own_cyc && expire && !i_wb_s_ack;
  assign done    = own_cyc && (i_wb_s_ack || tmo);

  servant_mem_arb_wdog #(
    .LIMIT (TIMEOUT)
  ) u_wdog (
    .clk    (i_wb_clk),
    .rst_n  (i_wb_rst_n),
    .clr    (!busy),
    .en     (busy && !i_wb_s_ack),
    .expire (expire)
  );

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      state <= IDLE;
      owner <= OWN_NONE;
      last  <= OWN_M1;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (i_wb_m0_cyc || i_wb_m1_cyc) begin
          state_nxt = BUSY;
          if (i_wb_m0_cyc && i_wb_m1_cyc) begin
            owner_nxt = (FIXED_M0 || (last == OWN_M1)) ? OWN_M0 : OWN_M1;
          end else begin
            owner_nxt = i_wb_m0_cyc ? OWN_M0 : OWN_M1;
          end
        end
      end
      BUSY: begin
        if (!own_cyc) begin
          // Abort: release the slave without touching the fairness history
          state_nxt = IDLE;
          owner_nxt = OWN_NONE;
        end else if (done) begin
          state_nxt = IDLE;
          owner_nxt = OWN_NONE;
          last_nxt  = owner;
        end
      end
      default: begin
        state_nxt = IDLE;
        owner_nxt = OWN_NONE;
      end
    endcase
  end

  always_comb begin
    o_wb_s_adr  = '0;
    o_wb_s_dat  = '0;
    o_wb_s_sel  = '0;
    o_wb_s_we   = 1'b0;
    o_wb_m0_rdt = '0;
    o_wb_m0_ack = 1'b0;
    o_wb_m1_rdt = '0;
    o_wb_m1_ack = 1'b0;
    o_wb_s_cyc  = own_cyc && !tmo;
    o_timeout   = tmo;
    if (own_m0) begin
      o_wb_s_adr  = i_wb_m0_adr;
      o_wb_s_dat  = i_wb_m0_dat;
      o_wb_s_sel  = i_wb_m0_sel;
      o_wb_s_we   = i_wb_m0_we;
      o_wb_m0_rdt = tmo ? ERR_DATA : i_wb_s_rdt;
      o_wb_m0_ack = done;
    end else if (own_m1) begin
      o_wb_s_adr  = i_wb_m1_adr;
      o_wb_s_dat  = i_wb_m1_dat;
      o_wb_s_sel  = i_wb_m1_sel;
      o_wb_s_we   = i_wb_m1_we;
      o_wb_m1_rdt = tmo ? ERR_DATA : i_wb_s_rdt;
      o_wb_m1_ack = done;
    end
  end

  assign o_grant = owner;

endmodule

// File: tb/tb_servant_mem_arb.sv
// Bench for servant_mem_arb: a round-robin and a fixed-priority instance share
// master stimulus; a transaction-level model is compared every cycle.
module tb_servant_mem_arb;

  localparam int TMO = 15;
  localparam logic [31:0] ERR = 32'hDEADBEEF;
  localparam int AUTO = 0, NEVER = 1, FORCE = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]       cyc = '0, we = '0;
  logic [1:0][31:0] adr = '0, dat = '0;
  logic [1:0][3:0]  sel = '0;
  logic [31:0]      s_rdt = '0;
  int               mode = AUTO;
  logic             force_ack = 1'b0;

  logic [1:0][31:0] s_adr_o, s_dat_o, m0_rdt_o, m1_rdt_o;
  logic [1:0][3:0]  s_sel_o;
  logic [1:0][1:0]  grant_o;
  logic [1:0]       s_we_o, s_cyc_o, m0_ack_o, m1_ack_o, tmo_o;
  logic [1:0]       ack_r, s_ack;

  int checks = 0, errors = 0;

  servant_mem_arb #(.AW(32), .PRIO("RR"), .TIMEOUT(TMO), .ERR_DATA(ERR)) dut_rr (
    .i_wb_clk(clk), .i_wb_rst_n(rst_n),
    .i_wb_m0_adr(adr[0]), .i_wb_m0_dat(dat[0]), .i_wb_m0_sel(sel[0]),
    .i_wb_m0_we(we[0]), .i_wb_m0_cyc(cyc[0]),
    .o_wb_m0_rdt(m0_rdt_o[0]), .o_wb_m0_ack(m0_ack_o[0]),
    .i_wb_m1_adr(adr[1]), .i_wb_m1_dat(dat[1]), .i_wb_m1_sel(sel[1]),
    .i_wb_m1_we(we[1]), .i_wb_m1_cyc(cyc[1]),
    .o_wb_m1_rdt(m1_rdt_o[0]), .o_wb_m1_ack(m1_ack_o[0]),
    .o_wb_s_adr(s_adr_o[0]), .o_wb_s_dat(s_dat_o[0]), .o_wb_s_sel(s_sel_o[0]),
    .o_wb_s_we(s_we_o[0]), .o_wb_s_cyc(s_cyc_o[0]),
    .i_wb_s_rdt(s_rdt), .i_wb_s_ack(s_ack[0]),
    .o_grant(grant_o[0]), .o_timeout(tmo_o[0])
  );

  servant_mem_arb #(.AW(32), .PRIO("M0"), .TIMEOUT(TMO), .ERR_DATA(ERR)) dut_m0 (
    .i_wb_clk(clk), .i_wb_rst_n(rst_n),
    .i_wb_m0_adr(adr[0]), .i_wb_m0_dat(dat[0]), .i_wb_m0_sel(sel[0]),
    .i_wb_m0_we(we[0]), .i_wb_m0_cyc(cyc[0]),
    .o_wb_m0_rdt(m0_rdt_o[1]), .o_wb_m0_ack(m0_ack_o[1]),
    .i_wb_m1_adr(adr[1]), .i_wb_m1_dat(dat[1]), .i_wb_m1_sel(sel[1]),
    .i_wb_m1_we(we[1]), .i_wb_m1_cyc(cyc[1]),
    .o_wb_m1_rdt(m1_rdt_o[1]), .o_wb_m1_ack(m1_ack_o[1]),
    .o_wb_s_adr(s_adr_o[1]), .o_wb_s_dat(s_dat_o[1]), .o_wb_s_sel(s_sel_o[1]),
    .o_wb_s_we(s_we_o[1]), .o_wb_s_cyc(s_cyc_o[1]),
    .i_wb_s_rdt(s_rdt), .i_wb_s_ack(s_ack[1]),
    .o_grant(grant_o[1]), .o_timeout(tmo_o[1])
  );

  // Slave per instance: servant_ram-like ack one cycle after cyc, or forced/never
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack_r <= '0;
    else for (int k = 0; k < 2; k++) ack_r[k] <= (mode == AUTO) && s_cyc_o[k] && !ack_r[k];
  end
  assign s_ack[0] = (mode == AUTO) ? ack_r[0] : ((mode == FORCE) && force_ack);
  assign s_ack[1] = (mode == AUTO) ? ack_r[1] : ((mode == FORCE) && force_ack);

  // Transaction model: busy flag, owner index, last winner, cycles spent busy
  bit mb[2]  = '{1'b0, 1'b0};
  int mo[2]  = '{0, 0};
  int ml[2]  = '{1, 1};
  int mc[2]  = '{0, 0};

  function automatic bit f_oc(int k);
    return mb[k] && cyc[mo[k]];
  endfunction

  function automatic bit f_to(int k);
    return f_oc(k) && !s_ack[k] && (mc[k] + 1 == TMO);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        mb[k] = 1'b0; mo[k] = 0; ml[k] = 1; mc[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (!mb[k]) begin
          if (cyc != 2'b00) begin
            if (cyc == 2'b11) mo[k] = (k == 1 || ml[k] == 1) ? 0 : 1;
            else              mo[k] = cyc[0] ? 0 : 1;
            mb[k] = 1'b1;
            mc[k] = 0;
          end
        end else if (!f_oc(k)) begin
          mb[k] = 1'b0;
        end else if (s_ack[k] || f_to(k)) begin
          mb[k] = 1'b0;
          ml[k] = mo[k];
        end else begin
          mc[k] = mc[k] + 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d actual=%0h expected=%0h t=%0t", nm, k, act, exp, $time);
    end
  endtask

  int gq0[$], gq1[$];
  logic [1:0][1:0] gprev = '0;
  int tmo_cnt = 0;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit oc, to, o0, o1;
      oc = f_oc(k);
      to = f_to(k);
      o0 = mb[k] && mo[k] == 0;
      o1 = mb[k] && mo[k] == 1;
      chk("s_cyc",   k, 32'(s_cyc_o[k]),  32'(oc && !to));
      chk("grant",   k, 32'(grant_o[k]),  mb[k] ? ((mo[k] == 0) ? 32'd1 : 32'd2) : 32'd0);
      chk("timeout", k, 32'(tmo_o[k]),    32'(to));
      chk("s_adr",   k, s_adr_o[k],       mb[k] ? adr[mo[k]] : 32'd0);
      chk("s_dat",   k, s_dat_o[k],       mb[k] ? dat[mo[k]] : 32'd0);
      chk("s_sel",   k, 32'(s_sel_o[k]),  mb[k] ? 32'(sel[mo[k]]) : 32'd0);
      chk("s_we",    k, 32'(s_we_o[k]),   mb[k] ? 32'(we[mo[k]]) : 32'd0);
      chk("m0_ack",  k, 32'(m0_ack_o[k]), 32'(o0 && oc && (s_ack[k] || to)));
      chk("m1_ack",  k, 32'(m1_ack_o[k]), 32'(o1 && oc && (s_ack[k] || to)));
      chk("m0_rdt",  k, m0_rdt_o[k],      o0 ? (to ? ERR : s_rdt) : 32'd0);
      chk("m1_rdt",  k, m1_rdt_o[k],      o1 ? (to ? ERR : s_rdt) : 32'd0);
    end
    if (gprev[0] == 2'b00 && grant_o[0] != 2'b00) gq0.push_back(int'(grant_o[0]));
    if (gprev[1] == 2'b00 && grant_o[1] != 2'b00) gq1.push_back(int'(grant_o[1]));
    gprev = grant_o;
    if (tmo_o[0]) tmo_cnt++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc = '0; we = '0; force_ack = 1'b0; mode = AUTO;
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    step(1);
  endtask

  int rr_exp[4] = '{1, 2, 1, 2};

  initial begin
    #1 rst_n = 1'b0;
    cyc = 2'b11;
    step(2);
    for (int k = 0; k < 2; k++) begin
      chk("rst_grant", k, 32'(grant_o[k]), 32'd0);
      chk("rst_s_cyc", k, 32'(s_cyc_o[k]), 32'd0);
    end
    cyc = '0;
    rst_n = 1'b1;
    step(1);

    // Single m0 read
    adr[0] = 32'h100; sel[0] = 4'hF; s_rdt = 32'h12345678; cyc[0] = 1'b1;
    step(1);
    chk("t1_s_cyc", 0, 32'(s_cyc_o[0]), 32'd1);
    chk("t1_grant", 0, 32'(grant_o[0]), 32'd1);
    step(1);
    chk("t1_ack",  0, 32'(m0_ack_o[0]), 32'd1);
    chk("t1_rdt",  0, m0_rdt_o[0],      32'h12345678);
    chk("t1_m1ak", 0, 32'(m1_ack_o[0]), 32'd0);
    step(1);
    cyc[0] = 1'b0;
    step(2);

    // Contention, both held for four transfers
    do_reset();
    gq0.delete(); gq1.delete();
    adr[1] = 32'h200; s_rdt = 32'h11110000; cyc = 2'b11;
    step(12);
    cyc = '0;
    step(3);
    chk("rr_count", 0, 32'(gq0.size()), 32'd4);
    chk("m0_count", 1, 32'(gq1.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("rr_order", 0, 32'(gq0[i]), 32'(rr_exp[i]));
      chk("m0_order", 1, 32'(gq1[i]), 32'd1);
    end

    // Timeout on m1 write with a silent slave
    do_reset();
    tmo_cnt = 0;
    mode = NEVER;
    adr[1] = 32'h300; dat[1] = 32'hCAFEF00D; sel[1] = 4'h3; we[1] = 1'b1;
    s_rdt = 32'h0BADF00D; cyc[1] = 1'b1;
    step(14);
    chk("t3_pre_tmo", 0, 32'(tmo_o[0]),    32'd0);
    chk("t3_pre_ack", 0, 32'(m1_ack_o[0]), 32'd0);
    step(1);
    for (int k = 0; k < 2; k++) begin
      chk("t3_ack",   k, 32'(m1_ack_o[k]), 32'd1);
      chk("t3_rdt",   k, m1_rdt_o[k],      32'hDEADBEEF);
      chk("t3_tmo",   k, 32'(tmo_o[k]),    32'd1);
      chk("t3_s_cyc", k, 32'(s_cyc_o[k]),  32'd0);
    end
    step(1);
    chk("t3_idle", 0, 32'(grant_o[0]), 32'd0);
    cyc[1] = 1'b0; we[1] = 1'b0;
    step(2);
    chk("t3_pulses", 0, 32'(tmo_cnt), 32'd1);

    // Abort by m0 with m1 pending
    do_reset();
    mode = NEVER;
    adr[0] = 32'h400; cyc[0] = 1'b1;
    step(1);
    adr[1] = 32'h500; cyc[1] = 1'b1;
    step(1);
    cyc[0] = 1'b0;
    #1;
    chk("t4_s_cyc", 0, 32'(s_cyc_o[0]),  32'd0);
    chk("t4_m0ack", 0, 32'(m0_ack_o[0]), 32'd0);
    chk("t4_m1ack", 0, 32'(m1_ack_o[0]), 32'd0);
    step(1);
    chk("t4_idle", 0, 32'(grant_o[0]), 32'd0);
    step(1);
    chk("t4_m1gnt", 0, 32'(grant_o[0]), 32'd2);
    chk("t4_adr",   0, s_adr_o[0],       32'h500);
    cyc[1] = 1'b0;
    step(2);

    // Asynchronous reset while m1 owns the slave
    do_reset();
    adr[0] = 32'h600; adr[1] = 32'h700; cyc = 2'b11;
    step(4);
    chk("t5_m1gnt", 0, 32'(grant_o[0]), 32'd2);
    mode = NEVER;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_s_cyc", 0, 32'(s_cyc_o[0]),  32'd0);
    chk("t5_grant", 0, 32'(grant_o[0]),  32'd0);
    chk("t5_m0ack", 0, 32'(m0_ack_o[0]), 32'd0);
    chk("t5_m1ack", 0, 32'(m1_ack_o[0]), 32'd0);
    step(1);
    rst_n = 1'b1; mode = AUTO;
    step(1);
    chk("t5_first", 0, 32'(grant_o[0]), 32'd1);
    cyc = '0;
    step(3);

    // Slave ack collides with expiry, then a stray ack while idle
    do_reset();
    mode = FORCE; s_rdt = 32'h0;
    adr[0] = 32'h800; cyc[0] = 1'b1;
    step(14);
    chk("t6_pre_ack", 0, 32'(m0_ack_o[0]), 32'd0);
    step(1);
    force_ack = 1'b1; s_rdt = 32'hA5A5A5A5;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("t6_ack", k, 32'(m0_ack_o[k]), 32'd1);
      chk("t6_rdt", k, m0_rdt_o[k],      32'hA5A5A5A5);
      chk("t6_tmo", k, 32'(tmo_o[k]),    32'd0);
    end
    step(1);
    cyc[0] = 1'b0;
    #1;
    chk("t6_stray_m0", 0, 32'(m0_ack_o[0]), 32'd0);
    chk("t6_stray_m1", 0, 32'(m1_ack_o[0]), 32'd0);
    chk("t6_stray_gn", 0, 32'(grant_o[0]),  32'd0);
    step(1);
    force_ack = 1'b0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
